sid_write_tx: RTL and testbench



---
 rtl/sid_write_tx.sv | 188 ++++++++++++++++++
 tb/tb_sid_write_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_write_tx.sv
// sid_write_tx: queues SID (addr, data) writes and sends each as two 8N1 UART bytes, address first.
// Optional `SID_TX_GAP_EN adds one idle bit time after every data byte.
module sid_write_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [15:0]                    prescale,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [4:0]                     wr_addr,
  input  logic [7:0]                     wr_data,
  output logic                           txd,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef SID_TX_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t state;
  state_t state_next;

  logic [12:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic [12:0]   pair_q;
  logic [15:0]   presc_q;
  logic [18:0]   bit_cnt;
  logic [18:0]   bit_last;
  logic [2:0]    bit_idx;
  logic          sel;
  logic          txd_q;

  logic          push;
  logic          pop;
  logic          bit_done;
  logic          tx_bit;
  logic [7:0]    cur_byte;

  assign wr_ready   = (level != LW'(FIFO_DEPTH));
  assign push       = wr_valid & wr_ready;
  assign fifo_level = level;
  assign busy       = (state != S_IDLE) | (level != '0);
  assign txd        = txd_q;

  assign bit_last = {presc_q, 3'b000} - 19'd1;
  assign bit_done = (bit_cnt == bit_last);

  // Storage carries no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {wr_addr, wr_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (level != '0) begin
          state_next = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done && (bit_idx == 3'd7)) begin
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (!sel) begin
            state_next = S_START;
          end else begin
`ifdef SID_TX_GAP_EN
            state_next = S_GAP;
`else
            state_next = S_IDLE;
`endif
          end
        end
      end
`ifdef SID_TX_GAP_EN
      S_GAP: begin
        if (bit_done) begin
          state_next = S_IDLE;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // The address byte is zero-extended so it can never exceed 0x1F on the wire.
  always_comb begin
    pop      = (state == S_IDLE) && (level != '0);
    cur_byte = sel ? pair_q[7:0] : {3'b000, pair_q[12:8]};
    tx_bit   = 1'b1;
    case (state)
      S_START: tx_bit = 1'b0;
      S_DATA:  tx_bit = cur_byte[bit_idx];
      default: tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_q  <= '0;
      presc_q <= 16'd1;
    end else if (pop) begin
      pair_q  <= mem[rd_ptr];
      presc_q <= (prescale == 16'd0) ? 16'd1 : prescale;
    end
  end

  // txd is registered, so the wire lags the state by one clock throughout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      sel     <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      txd_q <= tx_bit;
      if (state == S_IDLE || bit_done) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 19'd1;
      end
      if (state == S_DATA) begin
        if (bit_done) begin
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        bit_idx <= '0;
      end
      if (state == S_STOP && bit_done) begin
        sel <= ~sel;
      end
    end
  end

endmodule

// File: tb/tb_sid_write_tx.sv
// Testbench for sid_write_tx: a UART receiver model decodes txd and
// directed vectors plus timed sequences check bytes, latency and FIFO behaviour.
module tb_sid_write_tx;

`ifdef SID_TX_GAP_EN
  localparam int GAP_BITS = 1;
`else
  localparam int GAP_BITS = 0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] prescale;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        txd;
  logic        busy;
  logic [2:0]  fifo_level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] rx_q[$];
  int         rx_bit     = 16;
  bit         rx_en      = 0;
  int         frame_errs = 0;

  typedef struct {
    logic [15:0] presc;
    int          bits;
    logic [4:0]  addr;
    logic [7:0]  data;
    logic [7:0]  exp_a;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t vecs[4];

  sid_write_tx #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .prescale   (prescale),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .txd        (txd),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent 8N1 receiver sampling mid-bit on falling clock edges.
  always begin : rx_model
    logic [7:0] b;
    int         bt;
    @(negedge clk);
    if (rx_en && txd === 1'b0) begin
      bt = rx_bit;
      b  = 8'h00;
      repeat (bt / 2) @(negedge clk);
      if (txd !== 1'b0) frame_errs++;
      for (int i = 0; i < 8; i++) begin
        repeat (bt) @(negedge clk);
        b[i] = txd;
      end
      repeat (bt) @(negedge clk);
      if (txd !== 1'b1) frame_errs++;
      rx_q.push_back(b);
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic applyStimulus(input logic [4:0] a, input logic [7:0] d, output int acc_cyc);
    int n;
    n = 0;
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    acc_cyc  = -1;
    while (wr_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (wr_ready === 1'b1) begin
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
    end else begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end
    wr_valid = 1'b0;
  endtask

  task automatic waitBytes(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(name, rx_q.size(), n);
  endtask

  task automatic waitIdle(output int idle_cyc);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    idle_cyc = cyc;
    checkOutput("idle_timeout", busy, 1'b0);
  endtask

  function automatic logic [31:0] popByte();
    if (rx_q.size() == 0) return 32'hDEAD;
    return {24'h0, rx_q.pop_front()};
  endfunction

  initial begin : main
    int acc;
    int acc2;
    int idle;
    int acc_list[6];
    logic [7:0] exp_a[6];
    logic [7:0] exp_d[6];
    logic [31:0] got;
    int k;

    vecs[0] = '{16'd1, 8,  5'h1F, 8'hFF, 8'h1F, 8'hFF};
    vecs[1] = '{16'd0, 8,  5'h15, 8'hA5, 8'h15, 8'hA5};
    vecs[2] = '{16'd3, 24, 5'h00, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{16'd2, 16, 5'h0A, 8'h3C, 8'h0A, 8'h3C};

    rst      = 1'b1;
    prescale = 16'd2;
    wr_valid = 1'b0;
    wr_addr  = 5'h00;
    wr_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_txd", txd, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_level", fifo_level, 3'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_wr_ready", wr_ready, 1'b1);

    // Single write: latency, on-wire bytes and total duration.
    rx_en  = 1;
    rx_bit = 16;
    applyStimulus(5'h04, 8'h11, acc);
    checkOutput("lat_level_push", fifo_level, 3'd1);
    checkOutput("lat_txd_n", txd, 1'b1);
    @(negedge clk);
    checkOutput("lat_level_pop", fifo_level, 3'd0);
    checkOutput("lat_busy", busy, 1'b1);
    checkOutput("lat_txd_n1", txd, 1'b1);
    @(negedge clk);
    checkOutput("lat_txd_start", txd, 1'b0);
    waitIdle(idle);
    checkOutput("pair_duration", idle - acc, 321 + 16 * GAP_BITS);
    waitBytes("single_rx_count", 2, 10);
    checkOutput("single_addr", popByte(), 8'h04);
    checkOutput("single_data", popByte(), 8'h11);

    // Table of single writes over prescale values and byte patterns.
    for (int i = 0; i < 4; i++) begin
      prescale = vecs[i].presc;
      rx_bit   = vecs[i].bits;
      applyStimulus(vecs[i].addr, vecs[i].data, acc);
      waitBytes("vec_rx_count", 2, 25 * vecs[i].bits + 50);
      got = popByte();
      checkOutput($sformatf("vec%0d_addr", i), got, vecs[i].exp_a);
      checkOutput($sformatf("vec%0d_addr_hi", i), got & 32'hE0, 32'h0);
      checkOutput($sformatf("vec%0d_data", i), popByte(), vecs[i].exp_d);
      waitIdle(idle);
    end

    // Push coinciding with pop keeps the level constant.
    prescale = 16'd1;
    rx_bit   = 8;
    applyStimulus(5'h01, 8'h22, acc);
    applyStimulus(5'h18, 8'h0F, acc2);
    checkOutput("pp_first_level", fifo_level, 3'd1);
    k = 0;
    while (cyc < acc + 161 + 8 * GAP_BITS && k < 1000) begin
      @(negedge clk);
      k++;
    end
    applyStimulus(5'h1E, 8'h81, acc2);
    checkOutput("pp_accept_cycle", acc2 - acc, 162 + 8 * GAP_BITS);
    checkOutput("pp_level", fifo_level, 3'd1);
    waitBytes("pp_rx_count", 6, 600);
    checkOutput("pp_a0", popByte(), 8'h01);
    checkOutput("pp_d0", popByte(), 8'h22);
    checkOutput("pp_a1", popByte(), 8'h18);
    checkOutput("pp_d1", popByte(), 8'h0F);
    checkOutput("pp_a2", popByte(), 8'h1E);
    checkOutput("pp_d2", popByte(), 8'h81);
    waitIdle(idle);

    // FIFO fill: six back-to-back writes, the sixth stalls until the second pop.
    for (int i = 0; i < 6; i++) begin
      exp_a[i] = 8'(5'h10 + i);
      exp_d[i] = 8'(8'hC0 + 8'(i * 7));
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(exp_a[i][4:0], exp_d[i], acc_list[i]);
      if (i == 4) begin
        checkOutput("full_level", fifo_level, 3'd4);
        checkOutput("full_wr_ready", wr_ready, 1'b0);
        checkOutput("full_fill_cycles", acc_list[4] - acc_list[0], 4);
      end
    end
    checkOutput("full_sixth_accept", acc_list[5] - acc_list[0], 163 + 8 * GAP_BITS);
    waitBytes("full_rx_count", 12, 1500);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("full_a%0d", i), popByte(), exp_a[i]);
      checkOutput($sformatf("full_d%0d", i), popByte(), exp_d[i]);
    end
    waitIdle(idle);

    // Reset during the address byte's data bits, with one pair still queued.
    prescale = 16'd2;
    rx_bit   = 16;
    applyStimulus(5'h00, 8'h00, acc);
    applyStimulus(5'h07, 8'h33, acc2);
    k = 0;
    while (txd !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (64) @(negedge clk);
    checkOutput("mid_txd_before", txd, 1'b0);
    checkOutput("mid_level_before", fifo_level, 3'd1);
    rx_en = 0;
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_txd", txd, 1'b1);
    checkOutput("mid_rst_level", fifo_level, 3'd0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    rx_q.delete();
    frame_errs = 0;
    checkOutput("post_rst_txd", txd, 1'b1);
    checkOutput("post_rst_busy", busy, 1'b0);
    rx_en = 1;
    applyStimulus(5'h09, 8'h5A, acc);
    waitBytes("post_rst_rx_count", 2, 500);
    checkOutput("post_rst_addr", popByte(), 8'h09);
    checkOutput("post_rst_data", popByte(), 8'h5A);
    waitIdle(idle);
    checkOutput("frame_errors", frame_errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
